// File: rtl/mem_fetch_unit.sv
// rtl/mem_fetch_unit.sv - PC/IR/MDR front end with req/ack handshake to variable-latency memory
module mem_fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] PC_RESET   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic                  IorD,
    input  logic                  IRWrite,
    input  logic                  PCWrite,
    input  logic                  PCWriteIfZero,
    input  logic                  PCWriteIfNonZero,
    input  logic [1:0]            PCSource,
    input  logic [DATA_WIDTH-1:0] aluResult,
    input  logic [DATA_WIDTH-1:0] aluOut,
    input  logic                  zero,
    input  logic [DATA_WIDTH-1:0] storeData,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic [5:0]            opCode,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] mdr,
    output logic [DATA_WIDTH-1:0] pc,
    output logic                  stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] ir_q, ir_d;
    logic [DATA_WIDTH-1:0] mdr_q, mdr_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  irload_q, irload_d;
    logic                  stall_int;
    logic                  pc_wen;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            pc_q     <= PC_RESET;
            ir_q     <= '0;
            mdr_q    <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            irload_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            mdr_q    <= mdr_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            irload_q <= irload_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        mdr_d     = mdr_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        irload_d  = irload_q;
        stall_int = 1'b0;
        case (state_q)
            S_IDLE: begin
                stall_int = MemRead | MemWrite;
                if (MemRead || MemWrite) begin
                    state_d  = S_WAIT;
                    req_d    = 1'b1;
                    we_d     = MemWrite;
                    addr_d   = IorD ? aluOut : pc_q;
                    wdata_d  = storeData;
                    // A simultaneous read+write is a write: never loads IR or MDR.
                    irload_d = IRWrite & ~MemWrite;
                end
            end
            S_WAIT: begin
                stall_int = ~mem_ack;
                if (mem_ack) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    if (!we_q) begin
                        mdr_d = mem_rdata;
                        if (irload_q) begin
                            ir_d = mem_rdata;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // PC only moves when Control is actually advancing, so a fetch commits once.
    assign pc_wen = (PCWrite | (PCWriteIfZero & zero) | (PCWriteIfNonZero & ~zero)) & ~stall_int;

    always_comb begin
        pc_d = pc_q;
        if (pc_wen) begin
            case (PCSource)
                2'd0:    pc_d = aluResult;
                2'd1:    pc_d = aluOut;
                2'd2:    pc_d = {pc_q[DATA_WIDTH-1 -: 4], ir_q[25:0], 2'b00};
                default: pc_d = pc_q;
            endcase
        end
    end

    assign stall     = reset ? stall_int : 1'b0;
    assign opCode    = ir_q[DATA_WIDTH-1 -: 6];
    assign instr     = ir_q;
    assign mdr       = mdr_q;
    assign pc        = pc_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_fetch_unit.sv
// tb/tb_mem_fetch_unit.sv - self-checking bench for mem_fetch_unit
module tb_mem_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite, IorD, IRWrite;
    logic        PCWrite, PCWriteIfZero, PCWriteIfNonZero;
    logic [1:0]  PCSource;
    logic [31:0] aluResult, aluOut, storeData, mem_rdata;
    logic        zero, mem_ack;
    logic [5:0]  opCode;
    logic [31:0] instr, mdr, pc, mem_addr, mem_wdata;
    logic        stall, mem_req, mem_we;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } req_t;
    req_t sb_q[$];
    logic req_prev = 1'b0;

    typedef struct {
        logic        pcw, pcwz, pcwnz;
        logic [1:0]  src;
        logic        z;
        logic [31:0] res, out, exp_pc;
    } vec_t;
    vec_t vecs[9];

    mem_fetch_unit #(.DATA_WIDTH(32), .PC_RESET(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .PCWriteIfZero(PCWriteIfZero), .PCWriteIfNonZero(PCWriteIfNonZero),
        .PCSource(PCSource), .aluResult(aluResult), .aluOut(aluOut), .zero(zero),
        .storeData(storeData), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .opCode(opCode), .instr(instr), .mdr(mdr), .pc(pc), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: each new request is compared against the record pushed when it was driven.
    always @(negedge clk) begin
        if (reset && mem_req && !req_prev) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_req", 32'd1, 32'd0);
            end else begin
                req_t e;
                e = sb_q.pop_front();
                chk("sb_addr", mem_addr, e.addr);
                chk("sb_we", {31'd0, mem_we}, {31'd0, e.we});
                chk("sb_wdata", mem_wdata, e.wdata);
            end
        end
        req_prev <= mem_req;
    end

    task automatic idle_ctrl();
        MemRead = 0; MemWrite = 0; IorD = 0; IRWrite = 0;
        PCWrite = 0; PCWriteIfZero = 0; PCWriteIfNonZero = 0; PCSource = 2'd3;
        mem_ack = 0;
    endtask

    // Called #1 after a rising edge; returns #1 after the edge following the ack cycle.
    task automatic access(input string tag, input logic rd, input logic wr, input logic iord,
                          input logic irw, input logic pcw, input logic [1:0] src,
                          input logic [31:0] res, input logic [31:0] aout, input logic [31:0] sdata,
                          input int nwait, input logic [31:0] rdata, input logic [31:0] exp_addr);
        int stall_cnt;
        int req_cnt;
        stall_cnt = 0;
        req_cnt = 0;
        MemRead = rd; MemWrite = wr; IorD = iord; IRWrite = irw;
        PCWrite = pcw; PCSource = src; aluResult = res; aluOut = aout; storeData = sdata;
        mem_ack = 0;
        sb_q.push_back('{exp_addr, wr, sdata});
        @(negedge clk);
        if (stall) stall_cnt++;
        if (mem_req) req_cnt++;
        for (int i = 0; i < nwait; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (stall) stall_cnt++;
            if (mem_req) req_cnt++;
            chk({tag, "_addr_hold"}, mem_addr, exp_addr);
            chk({tag, "_wdata_hold"}, mem_wdata, sdata);
        end
        @(posedge clk); #1;
        mem_ack = 1; mem_rdata = rdata;
        @(negedge clk);
        if (stall) stall_cnt++;
        if (mem_req) req_cnt++;
        chk({tag, "_ack_we"}, {31'd0, mem_we}, {31'd0, wr});
        @(posedge clk); #1;
        idle_ctrl();
        chk({tag, "_req_drop"}, {31'd0, mem_req}, 32'd0);
        chk({tag, "_stall_cycles"}, stall_cnt, nwait + 1);
        chk({tag, "_req_cycles"}, req_cnt, nwait + 1);
    endtask

    initial begin
        idle_ctrl();
        aluResult = 0; aluOut = 0; storeData = 0; mem_rdata = 0; zero = 0;
        reset = 0;
        MemRead = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_mdr", mdr, 32'h0);
        chk("rst_opcode", {26'd0, opCode}, 32'd0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        MemRead = 0;
        reset = 1;

        access("fetch1", 1, 0, 0, 1, 1, 2'd0, 32'd4, 32'd0, 32'd0, 2, 32'h6800_0005, 32'h0);
        chk("fetch1_ir", instr, 32'h6800_0005);
        chk("fetch1_op", {26'd0, opCode}, 32'h1a);
        chk("fetch1_mdr", mdr, 32'h6800_0005);
        chk("fetch1_pc", pc, 32'd4);

        access("fetch2", 1, 0, 0, 1, 1, 2'd0, 32'd8, 32'd0, 32'd0, 0, 32'h0800_0010, 32'd4);
        chk("fetch2_ir", instr, 32'h0800_0010);
        chk("fetch2_pc", pc, 32'd8);

        access("store", 0, 1, 1, 0, 0, 2'd3, 32'd0, 32'h100, 32'hDEAD_BEEF, 1, 32'h1234_5678, 32'h100);
        chk("store_ir", instr, 32'h0800_0010);
        chk("store_mdr", mdr, 32'h0800_0010);
        chk("store_pc", pc, 32'd8);

        vecs[0] = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h200, 32'h0, 32'h200};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 32'h0, 32'h40, 32'h200};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 32'h0, 32'h40, 32'h40};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 32'h80, 32'h0, 32'h40};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 32'h80, 32'h0, 32'h80};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 32'h99, 32'h77, 32'h80};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 32'h0, 32'h1000_0000, 32'h1000_0000};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 32'h1000_0040};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 32'h5, 32'h6, 32'h1000_0040};
        for (int i = 0; i < 9; i++) begin
            PCWrite = vecs[i].pcw; PCWriteIfZero = vecs[i].pcwz; PCWriteIfNonZero = vecs[i].pcwnz;
            PCSource = vecs[i].src; zero = vecs[i].z;
            aluResult = vecs[i].res; aluOut = vecs[i].out;
            @(negedge clk);
            chk($sformatf("vec%0d_stall", i), {31'd0, stall}, 32'd0);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
        end
        idle_ctrl();
        zero = 0;

        access("rdwr", 1, 1, 0, 1, 0, 2'd3, 32'd0, 32'd0, 32'h0BAD_F00D, 0, 32'hFFFF_FFFF, 32'h1000_0040);
        chk("rdwr_ir", instr, 32'h0800_0010);
        chk("rdwr_mdr", mdr, 32'h0800_0010);

        MemRead = 1; IRWrite = 1; IorD = 0;
        @(posedge clk); #1;
        chk("midrst_req_before", {31'd0, mem_req}, 32'd1);
        reset = 0;
        #1;
        chk("midrst_req", {31'd0, mem_req}, 32'd0);
        chk("midrst_stall", {31'd0, stall}, 32'd0);
        chk("midrst_pc", pc, 32'h0);
        idle_ctrl();
        @(posedge clk); #1;
        reset = 1;
        mem_ack = 1; mem_rdata = 32'hAAAA_5555;
        @(posedge clk); #1;
        mem_ack = 0;
        @(negedge clk);
        chk("idle_ack_ir", instr, 32'h0);
        chk("idle_ack_mdr", mdr, 32'h0);
        chk("idle_ack_req", {31'd0, mem_req}, 32'd0);
        chk("idle_ack_stall", {31'd0, stall}, 32'd0);
        chk("sb_leftover", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
